// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (MDUOp 7-10).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [5:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        pwrite;

    logic        op_valid;
    logic        is_div;
    logic        sgn;
    logic        acc;
    logic        sub;

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [63:0] hilo;
    logic [63:0] res;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    logic        accept;
    logic        wr_ok;
    logic        mt_hi;
    logic        mt_lo;
    logic        commit;

    assign Busy   = (cnt != 6'd0);
    assign accept = Start && !Busy && !Req && op_valid;
    assign mt_hi  = (MDUOp == 4'd5) && !Busy && !Req;
    assign mt_lo  = (MDUOp == 4'd6) && !Busy && !Req;
    assign commit = (cnt == 6'd1) && pwrite;
    assign wr_ok  = !(is_div && (B == 32'd0));
    assign hilo   = {HI, LO};

    // Decode MDUOp into operation class and signedness.
    always_comb begin
        op_valid = 1'b0;
        is_div   = 1'b0;
        sgn      = 1'b0;
        acc      = 1'b0;
        sub      = 1'b0;
        case (MDUOp)
            4'd1: begin op_valid = 1'b1; sgn = 1'b1; end
            4'd2: begin op_valid = 1'b1; end
            4'd3: begin op_valid = 1'b1; is_div = 1'b1; sgn = 1'b1; end
            4'd4: begin op_valid = 1'b1; is_div = 1'b1; end
`ifdef MDU_MADD_EN
            4'd7: begin
                op_valid = 1'b1; acc = 1'b1; sgn = 1'b1;
            end
            4'd8: begin
                op_valid = 1'b1; acc = 1'b1;
            end
            4'd9: begin
                op_valid = 1'b1; acc = 1'b1; sub = 1'b1; sgn = 1'b1;
            end
            4'd10: begin
                op_valid = 1'b1; acc = 1'b1; sub = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Low 64 bits of the product of extended operands give the right
    // result for both signed and unsigned multiplies.
    always_comb begin
        a_ext = sgn ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext = sgn ? {{32{B[31]}}, B} : {32'd0, B};
        prod  = a_ext * b_ext;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. Overflow falls out naturally.
    always_comb begin
        a_neg  = sgn && A[31];
        b_neg  = sgn && B[31];
        a_mag  = a_neg ? (32'd0 - A) : A;
        b_mag  = b_neg ? (32'd0 - B) : B;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq     = a_mag / b_safe;
        ur     = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem    = a_neg ? (32'd0 - ur) : ur;
    end

    // Select the pending result for the accepted operation.
    always_comb begin
        if (is_div)
            res = {rem, quo};
        else if (acc)
            res = sub ? (hilo - prod) : (hilo + prod);
        else
            res = prod;
    end

    // Busy counter and pending result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 6'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
            pwrite <= 1'b0;
        end else if (accept) begin
            cnt    <= is_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
            p_hi   <= res[63:32];
            p_lo   <= res[31:0];
            pwrite <= wr_ok;
        end else if (Busy) begin
            cnt <= cnt - 6'd1;
        end
    end

    // HI/LO update: commit when the count expires, or direct moves when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else begin
            if (commit) begin
                HI <= p_hi;
                LO <= p_lo;
            end
            if (mt_hi)
                HI <= A;
            if (mt_lo)
                LO <= A;
        end
    end

endmodule
